mux_rr_arbiter: RTL

- Round-robin arbiter that shares one 4:1 data multiplexer among four requesters.
- Grants one requester at a time and drives the 2-bit mux select (address1:address0).
- Presents the selected requester's data on a valid/ready output port.
- Caps each grant at MAX_HOLD accepted transfers so no requester can starve the others.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/rr_pick.sv | 30 +++
 rtl/mux_rr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Requester count, select width, FSM states and index conversions.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(
        input logic [NUM_REQ-1:0] oh
    );
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(
        input logic [SEL_W-1:0] idx
    );
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr.
// Purely combinational; idx is only meaningful when any is high.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    // Rotate so bit 0 of rot is the requester at ptr.
    always_comb begin
        dbl = {req, req};
        rot = dbl[ptr +: NUM_REQ];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters,
// with a per-grant cap of MAX_HOLD accepted transfers.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       grant,
    output logic             address0,
    output logic             address1,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic             busy_w;
    logic             valid_w;
    logic             xfer;
    logic             last_xfer;
    logic             release_w;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] mux_data;

    assign busy_w    = (state_q == GRANT);
    assign valid_w   = busy_w & req[sel_q];
    assign xfer      = valid_w & out_ready;
    assign last_xfer = xfer & (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign release_w = busy_w & (~req[sel_q] | last_xfer);

    // On release the pointer moves past sel before re-arbitration.
    assign pick_ptr = busy_w ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        mux_data = '0;
        for (int b = 0; b < WIDTH; b++) begin
            unique case (sel_q)
                2'd0: mux_data[b] = in0[b];
                2'd1: mux_data[b] = in1[b];
                2'd2: mux_data[b] = in2[b];
                2'd3: mux_data[b] = in3[b];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    ptr_d = pick_ptr;
                    cnt_d = '0;
                    if (pick_any) begin
                        grant_d = idx_to_onehot(pick_idx);
                        sel_d   = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = busy_w;
    assign grant     = grant_q;
    assign address0  = sel_q[0];
    assign address1  = sel_q[1];
    assign out_valid = valid_w;
    assign out_data  = valid_w ? mux_data : '0;

endmodule
